// File: rtl/rr_encoder_32x5_pkg.sv
// rr_encoder_32x5_pkg: shared sizes and FSM state encoding for the round-robin request encoder.
package rr_encoder_32x5_pkg;
   localparam int N  = 32;
   localparam int IW = 5;
   typedef enum logic {S_IDLE = 1'b0, S_OFFER = 1'b1} state_t;
   function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
      return {{(N-1){1'b0}}, 1'b1} << idx;
   endfunction
endpackage

// File: rtl/rr_encoder_32x5_penc.sv
// rr_encoder_32x5_penc: combinational lowest-set-bit encoder, 32 lines to 5-bit index plus any flag.
module rr_encoder_32x5_penc
   import rr_encoder_32x5_pkg::*;
(
   input  logic [N-1:0]  vec_i,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);
   always_comb begin
      idx_o = '0;
      any_o = |vec_i;
      for (int i = N-1; i >= 0; i--)
         if (vec_i[i]) idx_o = IW'(i);
   end
endmodule

// File: rtl/rr_encoder_32x5.sv
// rr_encoder_32x5: collects request pulses into a pending set and offers one index at a time,
// round-robin from a pointer that advances past each acknowledged grant.
module rr_encoder_32x5
   import rr_encoder_32x5_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req_i,
   input  logic          ack_i,
   output logic          valid_o,
   output logic [IW-1:0] index_o,
   output logic [N-1:0]  pending_o
);
   state_t        state_q, state_d;
   logic [IW-1:0] index_q, index_d, ptr_q, ptr_d;
   logic [N-1:0]  pending_q, pending_d, clr_mask, hi_mask;
   logic [IW-1:0] hi_idx, all_idx, sel_idx;
   logic          hi_any, all_any;
   rr_encoder_32x5_penc u_hi (.vec_i(pending_q & hi_mask), .idx_o(hi_idx), .any_o(hi_any));
   rr_encoder_32x5_penc u_all (.vec_i(pending_q), .idx_o(all_idx), .any_o(all_any));
   assign hi_mask = {N{1'b1}} << ptr_q;
   assign sel_idx = hi_any ? hi_idx : all_idx;
   // A request arriving on the bit being cleared wins, so the source is served again later.
   assign clr_mask  = (state_q == S_OFFER && ack_i) ? onehot(index_q) : '0;
   assign pending_d = (pending_q & ~clr_mask) | req_i;
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      ptr_d   = ptr_q;
      if (state_q == S_IDLE) begin
         if (all_any) begin
            index_d = sel_idx;
            state_d = S_OFFER;
         end
      end else if (ack_i) begin
         ptr_d   = index_q + IW'(1);
         state_d = S_IDLE;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         index_q   <= '0;
         ptr_q     <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         ptr_q     <= ptr_d;
         pending_q <= pending_d;
      end
   end
   assign valid_o   = (state_q == S_OFFER);
   assign index_o   = index_q;
   assign pending_o = pending_q;
endmodule

// File: tb/tb_rr_encoder_32x5.sv
// tb_rr_encoder_32x5: directed and random stimulus against a behavioural round-robin model.
module tb_rr_encoder_32x5;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] req_i = '0;
   logic        ack_i = 1'b0;
   logic        valid_o;
   logic [4:0]  index_o;
   logic [31:0] pending_o;
   int n_chk = 0, n_err = 0;
   bit m_pend[32];
   bit m_valid;
   int m_idx, m_ptr;

   rr_encoder_32x5 dut (.clk(clk), .rst_n(rst_n), .req_i(req_i), .ack_i(ack_i),
                        .valid_o(valid_o), .index_o(index_o), .pending_o(pending_o));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_pend_word();
      logic [31:0] w = '0;
      for (int i = 0; i < 32; i++) w[i] = m_pend[i];
      return w;
   endfunction

   task automatic m_reset();
      foreach (m_pend[i]) m_pend[i] = 0;
      m_valid = 0; m_idx = 0; m_ptr = 0;
   endtask

   task automatic m_step(input logic [31:0] req, input logic ack);
      bit nxt[32];
      int clr = (m_valid && ack) ? m_idx : -1;
      for (int i = 0; i < 32; i++) nxt[i] = (m_pend[i] && i != clr) || req[i];
      if (!m_valid) begin
         for (int k = 0; k < 32; k++)
            if (!m_valid && m_pend[(m_ptr + k) % 32]) begin
               m_idx = (m_ptr + k) % 32;
               m_valid = 1;
            end
      end else if (ack) begin
         m_ptr = (m_idx + 1) % 32;
         m_valid = 0;
      end
      m_pend = nxt;
   endtask

   task automatic compare(input string tag);
      check({tag, "_valid"}, 32'(valid_o), 32'(m_valid));
      if (m_valid) check({tag, "_index"}, 32'(index_o), 32'(m_idx));
      check({tag, "_pend"}, pending_o, m_pend_word());
   endtask

   task automatic cycle(input logic [31:0] req, input logic ack);
      req_i = req;
      ack_i = ack;
      @(posedge clk);
      m_step(req, ack);
      #1;
      compare("cyc");
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      m_reset();
      #1;
      check("rst_valid", 32'(valid_o), 32'h0);
      check("rst_index", 32'(index_o), 32'h0);
      check("rst_pend", pending_o, 32'h0);
      req_i = '0;
      ack_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_offer(input int exp);
      for (int i = 0; i < 8 && !valid_o; i++) cycle('0, 1'b0);
      check("offer_seen", 32'(valid_o), 32'h1);
      check("offer_index", 32'(index_o), 32'(exp));
   endtask

   initial begin
      m_reset();
      do_reset();
      // single request, held offer, then ack
      cycle(32'h0000_0100, 1'b0);
      check("single_lat1", 32'(valid_o), 32'h0);
      cycle('0, 1'b0);
      check("single_valid", 32'(valid_o), 32'h1);
      check("single_index", 32'(index_o), 32'd8);
      for (int i = 0; i < 5; i++) cycle('0, 1'b0);
      check("single_hold", 32'(index_o), 32'd8);
      cycle('0, 1'b1);
      check("single_clr", pending_o, 32'h0);
      check("single_drop", 32'(valid_o), 32'h0);
      // round-robin order with a bubble between grants
      do_reset();
      cycle(32'h8000_0003, 1'b1);
      wait_offer(0);
      cycle('0, 1'b1);
      check("rr_bubble", 32'(valid_o), 32'h0);
      wait_offer(1);
      cycle('0, 1'b1);
      wait_offer(31);
      cycle('0, 1'b1);
      check("rr_empty", pending_o, 32'h0);
      // wrap-around: pointer back at 0, then 31
      cycle(32'h4000_0020, 1'b0);
      wait_offer(5);
      cycle('0, 1'b1);
      wait_offer(30);
      cycle('0, 1'b1);
      cycle(32'h0000_0008, 1'b0);
      wait_offer(3);
      cycle('0, 1'b1);
      // simultaneous set and clear keeps the bit
      cycle(32'h0000_0010, 1'b0);
      wait_offer(4);
      cycle(32'h0000_0010, 1'b1);
      check("setclr_pend", pending_o, 32'h0000_0010);
      wait_offer(4);
      cycle('0, 1'b1);
      // reset during an offer
      cycle(32'h0000_0080, 1'b0);
      wait_offer(7);
      do_reset();
      for (int i = 0; i < 3; i++) cycle('0, 1'b0);
      check("post_rst_idle", 32'(valid_o), 32'h0);
      // random traffic, occasional reset
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         cycle($urandom & $urandom & $urandom, 1'($urandom_range(0, 2) != 0));
      end
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
